pending_prio_encoder: RTL

PENDING_PRIO_ENCODER -- requirements
Module: pending_prio_encoder

---
 rtl/pending_prio_encoder_if.sv | 25 ++
 rtl/pending_prio_encoder.sv | 81 ++++++++
 2 files changed

// File: rtl/pending_prio_encoder_if.sv
// Bus bundle for pending_prio_encoder: request inputs, grant output handshake and status.
// master drives requests/clear/ready; slave is the encoder.
interface pending_prio_encoder_if #(
   parameter int unsigned WIDTH = 8
);
   localparam int unsigned IDXW = $clog2(WIDTH);

   logic [WIDTH-1:0] req_in;
   logic             clr;
   logic             out_ready;
   logic             out_valid;
   logic [IDXW-1:0]  out_idx;
   logic [WIDTH-1:0] pending;
   logic             overflow;

   modport master (
      output req_in, clr, out_ready,
      input  out_valid, out_idx, pending, overflow
   );

   modport slave (
      input  req_in, clr, out_ready,
      output out_valid, out_idx, pending, overflow
   );
endinterface

// File: rtl/pending_prio_encoder.sv
// Pending-request register feeding a registered priority encoder with valid/ready output.
// Define PRIO_ROUND_ROBIN_EN for rotating priority; default is fixed priority (highest index wins).
module pending_prio_encoder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   pending_prio_encoder_if.slave bus
);
   localparam int unsigned IDXW = $clog2(WIDTH);

   logic [WIDTH-1:0] pend_q;
   logic             valid_q;
   logic [IDXW-1:0]  idx_q;
   logic             ovf_q;

   logic [IDXW-1:0]  sel;
   logic [IDXW-1:0]  cand;
   logic             load;
   logic [WIDTH-1:0] load_mask;

`ifdef PRIO_ROUND_ROBIN_EN
   logic [IDXW-1:0]  last_idx;

   // Walk from the farthest candidate to the nearest so the first index below last_idx (with wrap) wins.
   always_comb begin
      sel  = '0;
      cand = '0;
      for (int unsigned k = WIDTH; k > 0; k--) begin
         cand = IDXW'((2 * WIDTH + 32'(last_idx) - k) % WIDTH);
         if (pend_q[cand]) sel = cand;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             last_idx <= '0;
      else if (load && !bus.clr) last_idx <= sel;
   end
`else
   always_comb begin
      sel  = '0;
      cand = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         cand = IDXW'(i);
         if (pend_q[cand]) sel = cand;
      end
   end
`endif

   assign load      = (!valid_q || bus.out_ready) && (|pend_q);
   assign load_mask = load ? (WIDTH'(1) << sel) : '0;

   // clr outranks both new requests and a load in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q  <= '0;
         valid_q <= 1'b0;
         idx_q   <= '0;
         ovf_q   <= 1'b0;
      end else if (bus.clr) begin
         pend_q  <= '0;
         valid_q <= 1'b0;
         idx_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         pend_q <= (pend_q & ~load_mask) | bus.req_in;
         ovf_q  <= |(bus.req_in & pend_q & ~load_mask);
         if (load) begin
            valid_q <= 1'b1;
            idx_q   <= sel;
         end else if (bus.out_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign bus.out_valid = valid_q;
   assign bus.out_idx   = idx_q;
   assign bus.pending   = pend_q;
   assign bus.overflow  = ovf_q;
endmodule
